// File: rtl/iommu_field_pkg.sv
// Shared SW access-permission encoding and next-value rule for IOMMU register fields.
// Latency: purely combinational helpers, no state.
// Backpressure: not applicable.
package iommu_field_pkg;

  typedef enum logic [2:0] {
    SwAccessRW,
    SwAccessRO,
    SwAccessWO,
    SwAccessW1C,
    SwAccessW1S,
    SwAccessW0C,
    SwAccessRC
  } sw_access_e;

  typedef enum logic {
    IDLE,
    RESP
  } field_fsm_e;

  // Widest supported field; narrower callers zero-extend and truncate.
  localparam int MaxDW = 64;

  // val: next stored value; err: access is illegal for this field;
  // chg: a legal write produced a value different from the current one.
  typedef struct packed {
    logic [MaxDW-1:0] val;
    logic             err;
    logic             chg;
  } sw_next_t;

  // Next field value for an accepted SW access. b is the HW-merged base value.
  // An RC read returns zero here; the caller lets a same-cycle HW update win.
  function automatic sw_next_t sw_next_val(sw_access_e access, logic [MaxDW-1:0] q,
                                           logic [MaxDW-1:0] b, logic [MaxDW-1:0] wdata,
                                           logic we);
    sw_next_t r;
    r.val = b;
    r.err = 1'b0;
    r.chg = 1'b0;
    if (we) begin
      case (access)
        SwAccessRW, SwAccessWO: r.val = wdata;
        SwAccessRO:             r.err = 1'b1;
        SwAccessW1C:            r.val = b & ~wdata;
        SwAccessW1S:            r.val = b | wdata;
        SwAccessW0C:            r.val = b & wdata;
        default:                r.val = b;
      endcase
    end else begin
      case (access)
        SwAccessWO: r.err = 1'b1;
        SwAccessRC: r.val = '0;
        default:    r.val = b;
      endcase
    end
    r.chg = we & ~r.err & (r.val != q);
    return r;
  endfunction

endpackage

// File: rtl/iommu_sw_field_rsp.sv
// SW access handshake: grant, one-entry response register and IDLE/RESP FSM.
// Latency: response valid the cycle after accept.
// Backpressure: response held stable until sw_rready_i; new request granted in the same cycle the response drains.
module iommu_sw_field_rsp
  import iommu_field_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          sw_req_i,
  output logic          sw_gnt_o,
  output logic          accept,
  input  logic [DW-1:0] rdataNext,
  input  logic          errNext,
  output logic          sw_rvalid_o,
  input  logic          sw_rready_i,
  output logic [DW-1:0] sw_rdata_o,
  output logic          sw_err_o
);

  field_fsm_e state, stateNext;

  assign accept      = sw_req_i & sw_gnt_o;
  assign sw_rvalid_o = (state == RESP);

  // State register; reset drops any pending response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= stateNext;
  end

  // Grant whenever the response slot is empty or being drained this cycle.
  always_comb begin
    stateNext = state;
    sw_gnt_o  = sw_req_i & ((state == IDLE) | sw_rready_i);
    case (state)
      IDLE:    if (sw_req_i) stateNext = RESP;
      RESP:    if (sw_rready_i && !sw_req_i) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Response payload: load on accept, clear once consumed so it reads 0 while idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sw_rdata_o <= '0;
      sw_err_o   <= 1'b0;
    end else if (accept) begin
      sw_rdata_o <= rdataNext;
      sw_err_o   <= errNext;
    end else if (state == RESP && sw_rready_i) begin
      sw_rdata_o <= '0;
      sw_err_o   <= 1'b0;
    end
  end

endmodule

// File: rtl/iommu_sw_field.sv
// One SW-accessible IOMMU register field with access semantics and HW update merge.
// Latency: q_o/qe_o update the cycle after accept; response valid the cycle after accept.
// Backpressure: sw_gnt_o withheld while a response waits for sw_rready_i.
module iommu_sw_field
  import iommu_field_pkg::*;
#(
  parameter int             DW       = 32,
  parameter sw_access_e     SWACCESS = SwAccessRW,
  parameter logic [DW-1:0]  RESVAL   = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          sw_req_i,
  input  logic          sw_we_i,
  input  logic [DW-1:0] sw_wdata_i,
  output logic          sw_gnt_o,
  output logic          sw_rvalid_o,
  input  logic          sw_rready_i,
  output logic [DW-1:0] sw_rdata_o,
  output logic          sw_err_o,
  input  logic          hw_de_i,
  input  logic [DW-1:0] hw_d_i,
  output logic [DW-1:0] q_o,
  output logic          qe_o
);

  logic [DW-1:0] q, base, nextQ, rdataNext;
  sw_next_t      swRes;
  logic          accept;
  logic          rcRead;
  logic          unusedHi;

  assign base   = hw_de_i ? hw_d_i : q;
  assign swRes  = sw_next_val(SWACCESS, MaxDW'(q), MaxDW'(base), MaxDW'(sw_wdata_i), sw_we_i);
  assign rcRead = (SWACCESS == SwAccessRC) && !sw_we_i;
  // Read data is the pre-update value; writes and WO reads return zero.
  assign rdataNext = (sw_we_i || SWACCESS == SwAccessWO) ? '0 : q;
  assign unusedHi  = ^(swRes.val >> DW);
  assign q_o       = q;

  // Next field value: HW update alone, or the SW op applied on the merged base.
  always_comb begin
    nextQ = base;
    if (accept) begin
      nextQ = swRes.val[DW-1:0];
      // A HW set landing in the same cycle as a read-clear must not be lost.
      if (rcRead && hw_de_i) nextQ = hw_d_i;
    end
  end

  // Field storage and the write-changed pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q    <= RESVAL;
      qe_o <= 1'b0;
    end else begin
      q    <= nextQ;
      qe_o <= accept & swRes.chg;
    end
  end

  iommu_sw_field_rsp #(.DW(DW)) uRsp (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .sw_req_i    (sw_req_i),
    .sw_gnt_o    (sw_gnt_o),
    .accept      (accept),
    .rdataNext   (rdataNext),
    .errNext     (swRes.err),
    .sw_rvalid_o (sw_rvalid_o),
    .sw_rready_i (sw_rready_i),
    .sw_rdata_o  (sw_rdata_o),
    .sw_err_o    (sw_err_o)
  );

endmodule

// File: tb/tb_iommu_sw_field.sv
// Directed bench over five field flavours (RW, W1C, RC, RO, WO) with a response scoreboard.
// Latency: responses expected the cycle after grant.
// Backpressure: exercised on the RW field with rready held low.
module tb_iommu_sw_field;
  import iommu_field_pkg::*;

  localparam int NI = 5;

  function automatic sw_access_e accOf(int k);
    case (k)
      0:       return SwAccessRW;
      1:       return SwAccessW1C;
      2:       return SwAccessRC;
      3:       return SwAccessRO;
      default: return SwAccessWO;
    endcase
  endfunction

  function automatic logic [7:0] resOf(int k);
    case (k)
      0:       return 8'h5A;
      1:       return 8'hFF;
      2:       return 8'h81;
      3:       return 8'h33;
      default: return 8'h00;
    endcase
  endfunction

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       req    [NI];
  logic       we     [NI];
  logic [7:0] wdata  [NI];
  logic       rready [NI];
  logic       hwDe   [NI];
  logic [7:0] hwD    [NI];
  logic       gnt    [NI];
  logic       rvalid [NI];
  logic [7:0] rdata  [NI];
  logic       err    [NI];
  logic [7:0] q      [NI];
  logic       qe     [NI];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gInst
    iommu_sw_field #(.DW(8), .SWACCESS(accOf(g)), .RESVAL(resOf(g))) dut (
      .clk_i       (clk),
      .rst_ni      (rstN),
      .sw_req_i    (req[g]),
      .sw_we_i     (we[g]),
      .sw_wdata_i  (wdata[g]),
      .sw_gnt_o    (gnt[g]),
      .sw_rvalid_o (rvalid[g]),
      .sw_rready_i (rready[g]),
      .sw_rdata_o  (rdata[g]),
      .sw_err_o    (err[g]),
      .hw_de_i     (hwDe[g]),
      .hw_d_i      (hwD[g]),
      .q_o         (q[g]),
      .qe_o        (qe[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic popCheck(input int i);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty observed=0 expected=1 entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rsp_rdata", rdata[i], e.rdata);
      check("rsp_err", err[i], e.err);
    end
  endtask

  // One access with rready held high: grant in N, response/q/qe in N+1, idle in N+2.
  task automatic doAccess(input int i, input logic w, input logic [7:0] wd, input logic hde,
                          input logic [7:0] hd, input logic [7:0] expRd, input logic expErr,
                          input logic [7:0] expQv, input logic expQe);
    exp_t e;
    @(posedge clk); #1;
    req[i] = 1'b1; we[i] = w; wdata[i] = wd; hwDe[i] = hde; hwD[i] = hd; rready[i] = 1'b1;
    @(negedge clk);
    check("gnt", gnt[i], 1);
    check("rvalid_pre", rvalid[i], 0);
    e.rdata = expRd; e.err = expErr;
    sb.push_back(e);
    @(posedge clk); #1;
    req[i] = 1'b0; we[i] = 1'b0; hwDe[i] = 1'b0;
    @(negedge clk);
    check("rvalid", rvalid[i], 1);
    popCheck(i);
    check("q", q[i], expQv);
    check("qe", qe[i], expQe);
    @(posedge clk); #1;
    @(negedge clk);
    check("rvalid_drop", rvalid[i], 0);
    check("qe_pulse", qe[i], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rstN = 1'b0;
    for (int k = 0; k < NI; k++) begin
      req[k] = 0; we[k] = 0; wdata[k] = 0; rready[k] = 0; hwDe[k] = 0; hwD[k] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst_q", q[k], resOf(k));
      check("rst_rvalid", rvalid[k], 0);
      check("rst_rdata", rdata[k], 0);
      check("rst_err", err[k], 0);
      check("rst_qe", qe[k], 0);
    end
    @(posedge clk); #1;
    rstN = 1'b1;

    // RW: read reset value, write, then rewrite the same value (no qe).
    doAccess(0, 0, 8'h00, 0, 8'h00, 8'h5A, 0, 8'h5A, 0);
    doAccess(0, 1, 8'hC3, 0, 8'h00, 8'h00, 0, 8'hC3, 1);
    doAccess(0, 1, 8'hC3, 0, 8'h00, 8'h00, 0, 8'hC3, 0);
    // W1C applied on top of a simultaneous HW update.
    doAccess(1, 1, 8'h0F, 1, 8'hF1, 8'h00, 0, 8'hF0, 1);
    // RC: HW set wins over the clear, then a plain clear.
    doAccess(2, 0, 8'h00, 1, 8'h04, 8'h81, 0, 8'h04, 0);
    doAccess(2, 0, 8'h00, 0, 8'h00, 8'h04, 0, 8'h00, 0);
    // RO: write rejected; read fine.
    doAccess(3, 1, 8'hFF, 0, 8'h00, 8'h00, 1, 8'h33, 0);
    doAccess(3, 0, 8'h00, 0, 8'h00, 8'h33, 0, 8'h33, 0);
    // WO: read rejected and returns zero; write lands but stays unreadable.
    doAccess(4, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h00, 0);
    doAccess(4, 1, 8'h5A, 0, 8'h00, 8'h00, 0, 8'h5A, 1);
    doAccess(4, 0, 8'h00, 0, 8'h00, 8'h00, 1, 8'h5A, 0);

    // Backpressure on RW (q = C3): two back-to-back reads, rready low for 3 cycles.
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; rready[0] = 1'b0;
    @(negedge clk);
    check("bp_gnt_first", gnt[0], 1);
    e.rdata = 8'hC3; e.err = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    hwDe[0] = 1'b1; hwD[0] = 8'h77;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_rvalid_hold", rvalid[0], 1);
      check("bp_rdata_hold", rdata[0], 8'hC3);
      check("bp_gnt_blocked", gnt[0], 0);
      @(posedge clk); #1;
      hwDe[0] = 1'b0;
    end
    rready[0] = 1'b1;
    @(negedge clk);
    check("bp_gnt_second", gnt[0], 1);
    check("bp_rvalid_first", rvalid[0], 1);
    check("bp_q_hw", q[0], 8'h77);
    popCheck(0);
    e.rdata = 8'h77; e.err = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    check("bp_rvalid_second", rvalid[0], 1);
    popCheck(0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_rvalid_idle", rvalid[0], 0);

    // Reset while a response waits: response dropped, grant available at once.
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; rready[0] = 1'b0;
    @(posedge clk); #1;
    req[0] = 1'b0; rstN = 1'b0;
    @(negedge clk);
    check("rr_rvalid_before", rvalid[0], 1);
    @(posedge clk); #1;
    rstN = 1'b1; req[0] = 1'b1;
    @(negedge clk);
    check("rr_rvalid", rvalid[0], 0);
    check("rr_rdata", rdata[0], 0);
    check("rr_q", q[0], 8'h5A);
    check("rr_q_rc", q[2], 8'h81);
    check("rr_gnt", gnt[0], 1);
    e.rdata = 8'h5A; e.err = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    req[0] = 1'b0; rready[0] = 1'b1;
    @(negedge clk);
    check("rr_rvalid_after", rvalid[0], 1);
    popCheck(0);
    @(posedge clk); #1;
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
